result_serializer: RTL and testbench

RESULT_SERIALIZER -- requirements
Module: result_serializer

---
 rtl/result_serializer_if.sv | 27 ++
 rtl/result_serializer.sv | 134 +++++++++++++
 tb/tb_result_serializer.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/result_serializer_if.sv
// Output stream of the result serializer: one W-bit field per transfer,
// tagged with its field index and a last-field flag.
interface result_serializer_if #(
  parameter int unsigned W = 4
);
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [3:0]   out_index;
  logic         out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_index,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_index,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/result_serializer.sv
// Captures nine operator-unit results on start and streams them out one field per
// transfer over a valid/ready port, keeping a running XOR checksum of the frame.
module result_serializer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] Arithmetic,
  input  logic [W-1:0] Shift,
  input  logic [W-1:0] Relational,
  input  logic [W-1:0] Equality,
  input  logic [W-1:0] Bitwise,
  input  logic [W-1:0] Reduction,
  input  logic [W-1:0] Logical,
  input  logic [W-1:0] Concatenation,
  input  logic [W-1:0] Conditional,
  result_serializer_if.master out_if,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] chk
);

  localparam logic [3:0] LastIdx = 4'd8;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StDone
  } state_e;

  typedef logic [8:0][W-1:0] bank_t;

  state_e       state_q, state_d;
  bank_t        bank_q, bank_d;
  bank_t        fields_in;
  logic [3:0]   idx_q, idx_d;
  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;
  logic         last_q, last_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [W-1:0] chk_q, chk_d;
  logic         xfer;

  // Element 0 is Arithmetic, element 8 is Conditional.
  assign fields_in = {Conditional, Concatenation, Logical, Reduction, Bitwise,
                      Equality, Relational, Shift, Arithmetic};

  assign xfer = valid_q && out_if.out_ready;

  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    idx_d   = idx_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    chk_d   = chk_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          bank_d  = fields_in;
          chk_d   = '0;
          idx_d   = 4'd0;
          data_d  = fields_in[0];
          valid_d = 1'b1;
          last_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = StSend;
        end
      end
      StSend: begin
        if (xfer) begin
          chk_d = chk_q ^ data_q;
          if (idx_q == LastIdx) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            idx_d  = idx_q + 4'd1;
            data_d = bank_q[idx_q + 4'd1];
            last_d = (idx_q == LastIdx - 4'd1);
          end
        end
      end
      StDone: begin
        // start is not looked at here, which forces one IDLE cycle between frames.
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      bank_q  <= '0;
      idx_q   <= 4'd0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      chk_q   <= '0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      chk_q   <= chk_d;
    end
  end

  assign out_if.out_valid = valid_q;
  assign out_if.out_data  = data_q;
  assign out_if.out_index = idx_q;
  assign out_if.out_last  = last_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign chk              = chk_q;

endmodule

// File: tb/tb_result_serializer.sv
// Bench for result_serializer: table of frames checked through a word scoreboard,
// plus hand-written sequences for start pokes, mid-frame reset and held start.
module tb_result_serializer;

  localparam int unsigned W = 4;

  typedef logic [8:0][W-1:0] bank_t;

  typedef struct {
    logic [3:0]   idx;
    logic [W-1:0] data;
    logic         last;
  } word_t;

  typedef struct {
    bank_t        fld;
    int           stall_idx;
    int           stall_len;
    logic [W-1:0] exp_chk;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] f [9];
  logic         busy;
  logic         done;
  logic [W-1:0] chk;

  result_serializer_if #(.W(W)) bus ();

  result_serializer #(.W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .Arithmetic   (f[0]),
    .Shift        (f[1]),
    .Relational   (f[2]),
    .Equality     (f[3]),
    .Bitwise      (f[4]),
    .Reduction    (f[5]),
    .Logical      (f[6]),
    .Concatenation(f[7]),
    .Conditional  (f[8]),
    .out_if       (bus.master),
    .busy         (busy),
    .done         (done),
    .chk          (chk)
  );

  always #5 clk = ~clk;

  word_t exp_q[$];
  int    n_vec = 0;
  int    n_miss = 0;
  int    done_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic bank_t mk(input logic [W-1:0] a0, a1, a2, a3, a4, a5, a6, a7, a8);
    bank_t b;
    b[0] = a0; b[1] = a1; b[2] = a2; b[3] = a3; b[4] = a4;
    b[5] = a5; b[6] = a6; b[7] = a7; b[8] = a8;
    return b;
  endfunction

  // Scoreboard: every accepted word must match the head of the expected queue.
  always @(negedge clk) begin
    word_t e;
    if (!rst) begin
      if (done) done_seen++;
      check("last_flag", bus.out_last, bus.out_valid && (bus.out_index == 4'd8));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("word_index", bus.out_index, e.idx);
          check("word_data", bus.out_data, e.data);
          check("word_last", bus.out_last, e.last);
        end
      end
    end
  end

  task automatic push_frame(input bank_t fl);
    word_t w;
    for (int i = 0; i < 9; i++) begin
      w.idx  = 4'(i);
      w.data = fl[i];
      w.last = (i == 8);
      exp_q.push_back(w);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || bus.out_valid) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_timeout", n < 50, 1);
  endtask

  task automatic run_frame(input vec_t v, input bit scramble, input bit poke);
    int stalled = 0;
    int cyc = 0;
    int d0;
    bit got_done = 1'b0;
    wait_idle();
    for (int i = 0; i < 9; i++) f[i] = v.fld[i];
    push_frame(v.fld);
    d0 = done_seen;
    bus.out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (scramble) for (int i = 0; i < 9; i++) f[i] = '1;
    check("latency_valid", bus.out_valid, 1);
    check("latency_index", bus.out_index, 0);
    check("chk_cleared", chk, 0);
    while (!got_done && cyc < 60) begin
      if (bus.out_valid && (bus.out_index == 4'(v.stall_idx)) && stalled < v.stall_len) begin
        check("stall_data", bus.out_data, v.fld[v.stall_idx]);
        check("stall_index", bus.out_index, v.stall_idx);
        bus.out_ready = 1'b0;
        stalled++;
      end else begin
        bus.out_ready = 1'b1;
      end
      if (poke) begin
        check("busy_in_frame", busy, 1);
        start = bus.out_valid && (bus.out_index == 4'd2);
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (done) begin
        got_done = 1'b1;
        check("final_chk", chk, v.exp_chk);
        check("busy_in_done", busy, 1);
        check("valid_in_done", bus.out_valid, 0);
        if (poke) start = 1'b1;
      end
    end
    check("done_reached", got_done, 1);
    check("stall_cycles", stalled, v.stall_len);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
    check("chk_held", chk, v.exp_chk);
    repeat (2) @(posedge clk);
    #1;
    check("no_restart", bus.out_valid, 0);
    check("chk_held_idle", chk, v.exp_chk);
    check("done_pulse_count", done_seen - d0, 1);
  endtask

  vec_t vt[6];

  initial begin
    int n;
    int d0;
    int done_cnt;
    int first_done;
    int second_done;
    int vlow;

    vt[0] = '{mk(4'h8, 4'h1, 4'h1, 4'h1, 4'h2, 4'h1, 4'h1, 4'hB, 4'hC), 99, 0, 4'hC};
    vt[1] = '{mk(4'h8, 4'h1, 4'h1, 4'h1, 4'h2, 4'h1, 4'h1, 4'hB, 4'hC), 4, 3, 4'hC};
    vt[2] = '{mk(4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8), 99, 0, 4'h8};
    vt[3] = '{mk(4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF), 8, 2, 4'hF};
    vt[4] = '{mk(4'h5, 4'hA, 4'h5, 4'hA, 4'h5, 4'hA, 4'h5, 4'hA, 4'h5), 0, 1, 4'h5};
    vt[5] = '{mk(4'h3, 4'h5, 4'h6, 4'h9, 4'hA, 4'hC, 4'hF, 4'h0, 4'h7), 6, 4, 4'h7};

    rst = 1'b1;
    start = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 9; i++) f[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", bus.out_valid, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_index", bus.out_index, 0);
    check("rst_last", bus.out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_chk", chk, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table of frames; inputs are overwritten with 1111 right after capture.
    for (int k = 0; k < 6; k++) run_frame(vt[k], 1'b1, 1'b0);

    // start pokes at index 2 and during DONE must be ignored.
    run_frame(vt[0], 1'b0, 1'b1);

    // Reset at index 5 aborts the frame.
    wait_idle();
    for (int i = 0; i < 9; i++) f[i] = vt[2].fld[i];
    push_frame(vt[2].fld);
    bus.out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (bus.out_index != 4'd5 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_index5", bus.out_index, 5);
    #1 rst = 1'b1;
    #1;
    check("arst_valid", bus.out_valid, 0);
    check("arst_data", bus.out_data, 0);
    check("arst_index", bus.out_index, 0);
    check("arst_last", bus.out_last, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_chk", chk, 0);
    exp_q.delete();
    d0 = done_seen;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("arst_no_done", done_seen - d0, 0);
    check("arst_idle_valid", bus.out_valid, 0);
    run_frame(vt[0], 1'b0, 1'b0);

    // start held for 25 cycles: frames back to back with one IDLE cycle between.
    wait_idle();
    for (int i = 0; i < 9; i++) f[i] = vt[0].fld[i];
    push_frame(vt[0].fld);
    push_frame(vt[0].fld);
    push_frame(vt[0].fld);
    bus.out_ready = 1'b1;
    done_cnt = 0;
    first_done = 0;
    second_done = 0;
    vlow = 0;
    start = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      @(posedge clk); #1;
      if (!bus.out_valid) vlow++;
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) first_done = c;
        if (done_cnt == 2) second_done = c;
      end
    end
    start = 1'b0;
    check("held_done_count", done_cnt, 2);
    check("held_first_done", first_done, 10);
    check("held_frame_period", second_done - first_done, 11);
    check("held_valid_gaps", vlow, 4);
    n = 0;
    while (!done && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check("held_third_done", done, 1);
    check("held_third_chk", chk, 4'hC);
    wait_idle();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
    $fatal(1);
  end

endmodule
